// File: rtl/tff_chk_pkg.sv
// rtl/tff_chk_pkg.sv - shared constants for the toggle-flop lockstep checker
package tff_chk_pkg;

    // FSM state encoding; 2'b11 is illegal and recovers to SYNC
    localparam logic [1:0] SYNC  = 2'b00;
    localparam logic [1:0] TRACK = 2'b01;
    localparam logic [1:0] FAULT = 2'b10;

    // Bit positions inside mm_vec
    localparam int MM_SR = 2;
    localparam int MM_JK = 1;
    localparam int MM_D  = 0;

endpackage

// File: rtl/maj3.sv
// rtl/maj3.sv - combinational 3-input majority voter
//
// Ports:
//   a, b, c : voter inputs
//   y       : 1 when at least two inputs are 1
module maj3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/tff_lockstep_checker.sv
// rtl/tff_lockstep_checker.sv - lockstep monitor for three toggle-flop implementations
//
// Compares the SR-, JK- and D-based toggle flops against an internal
// reference, counts toggles and failing edges, and latches a sticky fault
// once MAX_ERR failing edges have been seen.
//
// Optional feature macro: TFF_CHK_RESYNC_EN
//   defined   : on a failing edge the reference re-follows the majority vote
//   undefined : the reference free-runs after SYNC
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   t          : toggle input shared with the upstream flops
//   q_sr/q_jk/q_d : upstream flop outputs
//   clr        : synchronous clear of counters and fault (highest priority)
//   state      : FSM state (SYNC/TRACK/FAULT)
//   mismatch   : one-cycle pulse per failing edge
//   mm_vec     : per-implementation mismatch {sr, jk, d}
//   toggle_cnt : edges with t=1 seen in TRACK, wraps
//   err_cnt    : failing edges, saturates
//   fault      : high while in FAULT
module tff_lockstep_checker
    import tff_chk_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int MAX_ERR = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t,
    input  logic             q_sr,
    input  logic             q_jk,
    input  logic             q_d,
    input  logic             clr,
    output logic [1:0]       state,
    output logic             mismatch,
    output logic [2:0]       mm_vec,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fault
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ERR_LIMIT = CNT_W'(MAX_ERR);

    logic             maj;
    logic             q_ref;
    logic [2:0]       mm_now;
    logic             any_mm;
    logic [CNT_W-1:0] err_inc;
    logic             hit_limit;
    logic             q_ref_track;

    maj3 u_maj3 (
        .a (q_sr),
        .b (q_jk),
        .c (q_d),
        .y (maj)
    );

    // Comparison against the pre-edge reference
    always_comb begin
        mm_now        = 3'b000;
        mm_now[MM_SR] = q_sr ^ q_ref;
        mm_now[MM_JK] = q_jk ^ q_ref;
        mm_now[MM_D]  = q_d  ^ q_ref;
    end

    assign any_mm    = |mm_now;
    assign err_inc   = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CNT_ONE;
    assign hit_limit = any_mm && (err_inc == ERR_LIMIT);

`ifdef TFF_CHK_RESYNC_EN
    // With three single-bit inputs at least two always agree, so a failing
    // edge always has a valid majority to resynchronise to.
    assign q_ref_track = any_mm ? (maj ^ t) : (q_ref ^ t);
`else
    assign q_ref_track = q_ref ^ t;
`endif

    assign fault = (state == FAULT);

    // FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SYNC;
        end else if (clr) begin
            state <= SYNC;
        end else begin
            case (state)
                SYNC:    state <= TRACK;
                TRACK:   state <= hit_limit ? FAULT : TRACK;
                FAULT:   state <= FAULT;
                default: state <= SYNC;
            endcase
        end
    end

    // Datapath: reference, comparison results and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_ref      <= 1'b0;
            mm_vec     <= 3'b000;
            mismatch   <= 1'b0;
            toggle_cnt <= '0;
            err_cnt    <= '0;
        end else if (clr) begin
            mm_vec     <= 3'b000;
            mismatch   <= 1'b0;
            toggle_cnt <= '0;
            err_cnt    <= '0;
        end else begin
            case (state)
                SYNC: begin
                    // Seed the reference from the vote; no comparison yet
                    q_ref    <= maj ^ t;
                    mm_vec   <= 3'b000;
                    mismatch <= 1'b0;
                end
                TRACK: begin
                    mm_vec   <= mm_now;
                    mismatch <= any_mm;
                    q_ref    <= q_ref_track;
                    if (t) begin
                        toggle_cnt <= toggle_cnt + CNT_ONE;
                    end
                    if (any_mm) begin
                        err_cnt <= err_inc;
                    end
                end
                FAULT: begin
                    // Counters frozen; reference keeps pace with t
                    mm_vec   <= 3'b000;
                    mismatch <= 1'b0;
                    q_ref    <= q_ref ^ t;
                end
                default: begin
                    mm_vec   <= 3'b000;
                    mismatch <= 1'b0;
                end
            endcase
        end
    end

endmodule
